// File: rtl/tree_drv_pkg.sv
// tree_drv_pkg: shared types and constants for the tree root ST/RD initiator.
package tree_drv_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int STATE_W   = 3;
    localparam int GCNT_W    = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE,
        S_START,
        S_GUARD,
        S_WAIT,
        S_HOLD
    } state_e;
endpackage

// File: rtl/drv_watchdog.sv
// drv_watchdog: saturating cycle counter that flags a root which never reports done.
module drv_watchdog #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYC);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clr ? '0 : (en && cnt_q != LIM) ? cnt_q + CW'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // A zero limit disables the watchdog entirely.
    assign expired = TIMEOUT_CYC != 0 && cnt_q == LIM;
endmodule

// File: rtl/tree_driver.sv
// tree_driver: accepts operand triples, runs one ST/RD job on a tree root,
// and returns the captured result (or a timeout error) on a valid/ready stream.
module tree_driver
    import tree_drv_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int GUARD       = 1,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] A2,
    output logic             ST,
    output logic [WIDTH-1:0] IN0,
    output logic [WIDTH-1:0] IN1,
    output logic [WIDTH-1:0] IN2,
    input  logic             RD,
    input  logic [WIDTH-1:0] RES,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_RES,
    output logic             OUT_ERR
);
    state_e            state_q, state_d;
    logic [GCNT_W-1:0] gcnt_q, gcnt_d;
    logic [WIDTH-1:0]  in0_q, in0_d, in1_q, in1_d, in2_q, in2_d;
    logic [WIDTH-1:0]  out_res_q, out_res_d;
    logic              st_q, st_d, out_valid_q, out_valid_d, out_err_q, out_err_d;
    logic              accept, sample, done, expired, wd_en;

    assign IN_READY = state_q == S_IDLE && !RST;
    assign accept   = IN_VALID && IN_READY;
    // The final guard edge already looks at RD, so RD is first sampled GUARD edges after the ST cycle.
    assign sample   = state_q == S_WAIT || (state_q == S_GUARD && gcnt_q == '0);
    assign done     = sample && (RD || expired);
    assign wd_en    = state_q inside {S_START, S_GUARD, S_WAIT};

    drv_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
        .clk     (CLK),
        .rst     (RST),
        .clr     (accept),
        .en      (wd_en),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = accept ? S_START : S_IDLE;
            S_START: state_d = S_GUARD;
            S_GUARD: state_d = done ? S_HOLD : (gcnt_q == '0 ? S_WAIT : S_GUARD);
            S_WAIT:  state_d = done ? S_HOLD : S_WAIT;
            S_HOLD:  state_d = OUT_READY ? S_IDLE : S_HOLD;
            default: state_d = S_IDLE;
        endcase
        gcnt_d      = state_q == S_START ? GCNT_W'(GUARD - 1) :
                      (state_q == S_GUARD && gcnt_q != '0) ? gcnt_q - GCNT_W'(1) : gcnt_q;
        st_d        = accept;
        in0_d       = accept ? A0 : in0_q;
        in1_d       = accept ? A1 : in1_q;
        in2_d       = accept ? A2 : in2_q;
        // RD beats a simultaneous timeout.
        out_res_d   = done ? (RD ? RES : '0) : out_res_q;
        out_err_d   = done ? !RD : out_err_q;
        out_valid_d = state_d == S_HOLD;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            gcnt_q      <= '0;
            st_q        <= 1'b0;
            in0_q       <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gcnt_q      <= gcnt_d;
            st_q        <= st_d;
            in0_q       <= in0_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_err_q   <= out_err_d;
        end
    end

    assign ST        = st_q;
    assign IN0       = in0_q;
    assign IN1       = in1_q;
    assign IN2       = in2_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_RES   = out_res_q;
    assign OUT_ERR   = out_err_q;
endmodule

// File: tb/tb_tree_driver.sv
// tb_tree_driver: directed checks of tree_driver with GUARD=2, TIMEOUT_CYC=8.
module tb_tree_driver;
    logic        clk, rst, in_valid, in_ready, st, rd, out_valid, out_ready, out_err, model;
    logic [15:0] a0, a1, a2, in0, in1, in2, res_drv, res_w, out_res;
    int          tests, fails, st_cnt, st0;
    logic [15:0] ta0[4] = '{16'h0001, 16'h0100, 16'hFFFF, 16'h1000};
    logic [15:0] ta1[4] = '{16'h0002, 16'h0020, 16'h0001, 16'h2000};
    logic [15:0] ta2[4] = '{16'h0003, 16'h0003, 16'h0000, 16'h4000};
    logic [15:0] tex[4] = '{16'h0006, 16'h0123, 16'h0000, 16'h7000};

    assign res_w = model ? 16'(in0 + in1 + in2) : res_drv;

    tree_driver #(.WIDTH(16), .GUARD(2), .TIMEOUT_CYC(8)) dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .A0(a0), .A1(a1), .A2(a2), .ST(st), .IN0(in0), .IN1(in1), .IN2(in2),
        .RD(rd), .RES(res_w), .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .OUT_RES(out_res), .OUT_ERR(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (st === 1'b1) st_cnt++;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0; fails = 0; st_cnt = 0; model = 1'b0;
        rst = 1'b1; in_valid = 1'b0; rd = 1'b0; out_ready = 1'b0;
        a0 = '0; a1 = '0; a2 = '0; res_drv = '0;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_st", st, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in0", in0, 0);
        chk("rst_out_res", out_res, 0);
        chk("rst_out_err", out_err, 0);
        step(); step();
        rst = 1'b0;
        #1 chk("post_rst_in_ready", in_ready, 1);

        // single job
        step();
        st_cnt = 0;
        in_valid = 1'b1; a0 = 16'd3; a1 = 16'd4; a2 = 16'd5; out_ready = 1'b1;
        step();
        chk("j1_st", st, 1);
        chk("j1_in0", in0, 3);
        chk("j1_in1", in1, 4);
        chk("j1_in2", in2, 5);
        chk("j1_in_ready", in_ready, 0);
        in_valid = 1'b0;
        step(); chk("j1_st_low", st, 0);
        step(); chk("j1_nv2", out_valid, 0);
        step(); chk("j1_nv3", out_valid, 0); chk("j1_in2_hold", in2, 5);
        rd = 1'b1; res_drv = 16'h0017;
        step();
        chk("j1_valid", out_valid, 1);
        chk("j1_res", out_res, 16'h0017);
        chk("j1_err", out_err, 0);
        rd = 1'b0;
        step();
        chk("j1_done", out_valid, 0);
        chk("j1_idle_ready", in_ready, 1);
        chk("j1_st_count", st_cnt, 1);
        chk("j1_in1_keep", in1, 4);

        // stale RD across ST/guard
        rd = 1'b1; res_drv = 16'hAAAA; out_ready = 1'b0;
        in_valid = 1'b1; a0 = 16'h10; a1 = 16'h11; a2 = 16'h12;
        step();
        in_valid = 1'b1; a0 = 16'd7; a1 = 16'd8; a2 = 16'd9;
        step(); chk("stale_g1", out_valid, 0);
        step(); chk("stale_g2", out_valid, 0);
        rd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk("stale_wait", out_valid, 0);
        end
        rd = 1'b1; res_drv = 16'h1234;
        step();
        chk("stale_valid", out_valid, 1);
        chk("stale_res", out_res, 16'h1234);
        chk("stale_err", out_err, 0);
        rd = 1'b0;

        // backpressure, second triple pending
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_res", out_res, 16'h1234);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_in0", in0, 16'h10);
        end
        out_ready = 1'b1;
        step();
        chk("bp_released", out_valid, 0);
        chk("bp_in0_kept", in0, 16'h10);
        step();
        chk("bp_accept_st", st, 1);
        chk("bp_accept_in0", in0, 7);
        in_valid = 1'b0;

        // timeout with RD never high
        for (int i = 0; i < 8; i++) begin
            step(); chk("to_wait", out_valid, 0);
        end
        step();
        chk("to_valid", out_valid, 1);
        chk("to_res", out_res, 0);
        chk("to_err", out_err, 1);
        step();
        in_valid = 1'b1; a0 = 16'd1; a1 = 16'd2; a2 = 16'd3;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(); chk("tie_wait", out_valid, 0);
        end
        rd = 1'b1; res_drv = 16'h5555;
        step();
        chk("tie_valid", out_valid, 1);
        chk("tie_err", out_err, 0);
        chk("tie_res", out_res, 16'h5555);
        rd = 1'b0;
        step();

        // reset in WAIT
        in_valid = 1'b1; a0 = 16'hA; a1 = 16'hB; a2 = 16'hC;
        step();
        in_valid = 1'b0;
        step(); step(); step(); step();
        rst = 1'b1; rd = 1'b1; res_drv = 16'h9999;
        #1;
        chk("rw_st", st, 0);
        chk("rw_out_valid", out_valid, 0);
        chk("rw_in0", in0, 0);
        chk("rw_in2", in2, 0);
        chk("rw_in_ready", in_ready, 0);
        step();
        rst = 1'b0;
        step();
        rd = 1'b0;
        chk("rw_no_result", out_valid, 0);
        chk("rw_ready", in_ready, 1);

        // reset while ST is high
        in_valid = 1'b1; a0 = 16'd9; a1 = 16'd9; a2 = 16'd9;
        step();
        chk("rs_st_high", st, 1);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1 chk("rs_st_drop", st, 0);
        step();
        rst = 1'b0;
        step();

        // back-to-back jobs with a zero-latency root
        model = 1'b1; rd = 1'b1; out_ready = 1'b1; st0 = st_cnt;
        for (int j = 0; j < 4; j++) begin
            a0 = ta0[j]; a1 = ta1[j]; a2 = ta2[j]; in_valid = 1'b1;
            for (int t = 0; t < 10 && st !== 1'b1; t++) step();
            chk("b2b_st", st, 1);
            chk("b2b_in0", in0, ta0[j]);
            for (int t = 0; t < 10 && out_valid !== 1'b1; t++) step();
            chk("b2b_valid", out_valid, 1);
            chk("b2b_res", out_res, tex[j]);
            chk("b2b_err", out_err, 0);
        end
        in_valid = 1'b0;
        step(); step(); step();
        chk("b2b_st_count", st_cnt - st0, 4);
        rd = 1'b0; model = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tree_driver.md
# tree_driver

Initiator side of the ST/RD start–done handshake used by every generated tree root and node. The block accepts operand triples from an upstream valid/ready stream, drives a root's IN0..IN2 and pulses ST, waits for RD, captures RES, and presents the result on a downstream valid/ready stream. A watchdog reports a root that never completes. It sits between the host-facing fabric and one root instance.

## Interface
Parameters:
- WIDTH, 16, operand/result width; matches root IN*/RES width.
- GUARD, 1, cycles after the ST cycle during which RD is ignored (stale-done mask); legal 1..15.
- TIMEOUT_CYC, 1024, cycles from ST to give-up; 0 disables watchdog.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  operand triple valid.
- IN_READY  out  1  block can accept a triple.
- A0, A1, A2  in  WIDTH  operands.
- ST  out  1  start pulse to root.
- IN0, IN1, IN2  out  WIDTH  operands to root, registered.
- RD  in  1  root done (level).
- RES  in  WIDTH  root result.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  downstream accepts result.
- OUT_RES  out  WIDTH  captured result.
- OUT_ERR  out  1  result produced by timeout, not by RD.

## Operation
- States: IDLE, START, GUARD, WAIT, HOLD.
- IDLE: IN_READY=1. On IN_VALID&IN_READY at an edge: A0..A2 registered into IN0..IN2, go START.
- START: ST=1 for exactly this one cycle; watchdog cleared and started; go GUARD.
- GUARD: ST=0; RD ignored for GUARD cycles; then WAIT.
- WAIT: on edge with RD=1: OUT_RES<=RES, OUT_ERR<=0, go HOLD. If watchdog reaches TIMEOUT_CYC first: OUT_RES<=0, OUT_ERR<=1, go HOLD. RD and timeout on same edge: RD wins (OUT_ERR=0).
- HOLD: OUT_VALID=1, OUT_RES/OUT_ERR stable; on OUT_VALID&OUT_READY edge go IDLE.
- IN0..IN2 held stable from START until next accepted triple (root may sample late).
- IN_READY=0 in all states except IDLE; no overlap of jobs, no input buffering.
- Watchdog counts cycles from the START edge inclusive; width ceil(log2(TIMEOUT_CYC+1)); saturates.
- RD is never synchronized; root is in the same clock domain.

## Timing
- Reset (async, immediate): state IDLE, ST=0, IN0..IN2=0, OUT_VALID=0, OUT_RES=0, OUT_ERR=0, watchdog=0. IN_READY=0 while RST high, 1 on first cycle after deassertion.
- Accept at edge k → ST high in cycle k..k+1 → RD first sampled at edge k+1+GUARD.
- RD high at edge m (m ≥ k+1+GUARD) → OUT_VALID high from edge m.
- Minimum triple-to-result: 2+GUARD edges; with OUT_READY held high, throughput one job per 3+GUARD+root latency cycles.
- RD high during GUARD is discarded; must still be high at or after first WAIT edge.
- OUT_READY high while OUT_VALID low has no effect.
- Reset mid-job: ST drops immediately, pending result discarded, no OUT_VALID produced.
- IN_VALID asserted in non-IDLE states: ignored, no handshake.

## Structure
- Shared package tree_drv_pkg: state enum (IDLE, START, GUARD, WAIT, HOLD), default WIDTH constant, state-width constant.
- One sub-module: drv_watchdog (clear, enable, TIMEOUT_CYC param, expired out); GUARD counter stays inline in the FSM.

## Test plan
- Single job: A0=3,A1=4,A2=5, root model RD 4 cycles after ST with RES=0x0017 → exactly one ST pulse, IN0..IN2=3,4,5 stable, OUT_VALID with OUT_RES=0x0017, OUT_ERR=0.
- Stale RD: RD held high before and through ST/GUARD, drops then rises after 3 cycles → result captured only on the later rise.
- Backpressure: OUT_READY low 10 cycles → OUT_VALID/OUT_RES stable, IN_READY=0, second IN_VALID not accepted until handshake completes.
- Timeout: TIMEOUT_CYC=8, RD never high → OUT_VALID 8 cycles after START edge, OUT_RES=0, OUT_ERR=1; RD on same edge as expiry → OUT_ERR=0.
- Reset mid-WAIT: RST pulsed → ST=0, OUT_VALID=0, IN0..IN2=0 immediately; next job runs normally.
- Back-to-back: 4 triples with IN_VALID always high, OUT_READY high → 4 results in order, one ST per triple.
